// File: rtl/stopwatch_pkg.sv
// Shared constants for the stopwatch sequencing controller: state encoding,
// preset field width and default wrap limits.
package stopwatch_pkg;

   localparam int STATE_W  = 3;
   localparam int PRESET_W = 6;

   localparam int MIN_MAX_DEF       = 59;
   localparam int SEC_MAX_DEF       = 59;
   localparam int REPEAT_DELAY_DEF  = 50_000_000;
   localparam int REPEAT_PERIOD_DEF = 10_000_000;

   localparam logic [STATE_W-1:0] ST_IDLE  = 3'd0;
   localparam logic [STATE_W-1:0] ST_PROG  = 3'd1;
   localparam logic [STATE_W-1:0] ST_RUN   = 3'd2;
   localparam logic [STATE_W-1:0] ST_PAUSE = 3'd3;
   localparam logic [STATE_W-1:0] ST_DONE  = 3'd4;

   // Increment with wrap to zero once the field reaches its limit.
   function automatic logic [PRESET_W-1:0] wrap_inc(input logic [PRESET_W-1:0] v,
                                                    input logic [PRESET_W-1:0] max_v);
      return (v >= max_v) ? '0 : v + 1'b1;
   endfunction

endpackage

// File: rtl/stopwatch_ctrl_btn_edge.sv
// Rising-edge detector for a debounced button level. History resets to 1 so a
// button held through reset release does not produce an event.
module btn_edge (
   input  logic clock,
   input  logic rst_n,
   input  logic level,
   output logic rise
);

   logic r_prev;

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) r_prev <= 1'b1;
      else        r_prev <= level;
   end

   assign rise = level & ~r_prev;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencing controller: buttons/switches -> run/load/clear commands,
// preset programming, capture and beep pulses.
// Optional auto-repeat of the inc button in PROG: STOPWATCH_CTRL_AUTOREPEAT_EN.
//
// state | meaning
// IDLE  | stopped, waiting for start or programming request
// PROG  | editing preset minutes:seconds
// RUN   | datapath counting
// PAUSE | counting suspended, time held
// DONE  | countdown expired, waiting for acknowledge
module stopwatch_ctrl
   import stopwatch_pkg::*;
#(
   parameter int MIN_MAX       = MIN_MAX_DEF,
   parameter int SEC_MAX       = SEC_MAX_DEF,
   parameter int REPEAT_DELAY  = REPEAT_DELAY_DEF,
   parameter int REPEAT_PERIOD = REPEAT_PERIOD_DEF
) (
   input  logic                clock,
   input  logic                rst_n,
   input  logic                btn_startstop,
   input  logic                btn_inc,
   input  logic                btn_clear,
   input  logic                sw_prog,
   input  logic                sw_up,
   input  logic                sw_min,
   input  logic                zero,
   output logic                run,
   output logic                dir_up,
   output logic                load,
   output logic                clear,
   output logic [PRESET_W-1:0] preset_min,
   output logic [PRESET_W-1:0] preset_sec,
   output logic                capture,
   output logic                beep,
   output logic [STATE_W-1:0]  state_out
);

   localparam logic [PRESET_W-1:0] MIN_LIM = PRESET_W'(MIN_MAX);
   localparam logic [PRESET_W-1:0] SEC_LIM = PRESET_W'(SEC_MAX);

   logic [STATE_W-1:0]  r_state;
   logic                r_run, r_dir_up, r_load, r_clear, r_capture, r_beep;
   logic [PRESET_W-1:0] r_preset_min, r_preset_sec;
   logic                w_ss_rise, w_inc_rise, w_clr_rise, w_inc_evt, w_preset_nz;

   btn_edge u_edge_ss  (.clock(clock), .rst_n(rst_n), .level(btn_startstop), .rise(w_ss_rise));
   btn_edge u_edge_inc (.clock(clock), .rst_n(rst_n), .level(btn_inc),       .rise(w_inc_rise));
   btn_edge u_edge_clr (.clock(clock), .rst_n(rst_n), .level(btn_clear),     .rise(w_clr_rise));

`ifdef STOPWATCH_CTRL_AUTOREPEAT_EN
   localparam logic [31:0] REP_DLY_LD = 32'(REPEAT_DELAY - 1);
   localparam logic [31:0] REP_PER_LD = 32'(REPEAT_PERIOD - 1);

   logic [31:0] r_rep_cnt;
   logic        r_rep_armed;
   logic        w_rep_fire;

   assign w_rep_fire = r_rep_armed && (r_rep_cnt == '0) && btn_inc && (r_state == ST_PROG);

   // Armed by the inc edge; first terminal count after the delay, then per period.
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         r_rep_cnt   <= '0;
         r_rep_armed <= 1'b0;
      end else if (r_state != ST_PROG || !btn_inc) begin
         r_rep_cnt   <= '0;
         r_rep_armed <= 1'b0;
      end else if (w_inc_rise) begin
         r_rep_cnt   <= REP_DLY_LD;
         r_rep_armed <= 1'b1;
      end else if (r_rep_armed) begin
         r_rep_cnt <= (r_rep_cnt == '0) ? REP_PER_LD : r_rep_cnt - 1'b1;
      end
   end

   assign w_inc_evt = w_inc_rise | w_rep_fire;
`else
   logic w_unused_rep;
   assign w_unused_rep = ^{REPEAT_DELAY, REPEAT_PERIOD};
   assign w_inc_evt    = w_inc_rise;
`endif

   assign w_preset_nz = (r_preset_min != '0) || (r_preset_sec != '0);

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= ST_IDLE;
         r_run        <= 1'b0;
         r_dir_up     <= 1'b1;
         r_load       <= 1'b0;
         r_clear      <= 1'b0;
         r_capture    <= 1'b0;
         r_beep       <= 1'b0;
         r_preset_min <= '0;
         r_preset_sec <= '0;
      end else begin
         r_load    <= 1'b0;
         r_clear   <= 1'b0;
         r_capture <= 1'b0;
         r_beep    <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (sw_prog) begin
                  r_state <= ST_PROG;
               end else if (w_ss_rise) begin
                  if (sw_up) begin
                     r_dir_up <= 1'b1;
                     r_clear  <= 1'b1;
                     r_run    <= 1'b1;
                     r_state  <= ST_RUN;
                  end else if (w_preset_nz) begin
                     r_dir_up <= 1'b0;
                     r_load   <= 1'b1;
                     r_run    <= 1'b1;
                     r_state  <= ST_RUN;
                  end
               end
            end
            ST_PROG: begin
               if (w_clr_rise) begin
                  r_preset_min <= '0;
                  r_preset_sec <= '0;
               end else if (w_inc_evt) begin
                  if (sw_min) r_preset_min <= wrap_inc(r_preset_min, MIN_LIM);
                  else        r_preset_sec <= wrap_inc(r_preset_sec, SEC_LIM);
               end
               if (!sw_prog) r_state <= ST_IDLE;
            end
            ST_RUN: begin
               if (w_clr_rise) begin
                  r_clear <= 1'b1;
                  r_run   <= 1'b0;
                  r_state <= ST_IDLE;
               end else if (zero && !r_dir_up) begin
                  r_beep  <= 1'b1;
                  r_run   <= 1'b0;
                  r_state <= ST_DONE;
               end else if (w_ss_rise) begin
                  r_capture <= r_dir_up;
                  r_run     <= 1'b0;
                  r_state   <= ST_PAUSE;
               end
            end
            ST_PAUSE: begin
               if (w_clr_rise) begin
                  r_clear <= 1'b1;
                  r_state <= ST_IDLE;
               end else if (w_ss_rise) begin
                  r_run   <= 1'b1;
                  r_state <= ST_RUN;
               end
            end
            ST_DONE: begin
               if (w_ss_rise || w_clr_rise) begin
                  r_clear <= 1'b1;
                  r_state <= ST_IDLE;
               end
            end
            default: begin
               r_run   <= 1'b0;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign run        = r_run;
   assign dir_up     = r_dir_up;
   assign load       = r_load;
   assign clear      = r_clear;
   assign capture    = r_capture;
   assign beep       = r_beep;
   assign preset_min = r_preset_min;
   assign preset_sec = r_preset_sec;
   assign state_out  = r_state;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Scoreboard bench for stopwatch_ctrl: stimulus queues expected observations,
// a monitor pops and compares whenever a pulse fires or a check is strobed.
module tb_stopwatch_ctrl;

   logic       clock = 1'b0;
   logic       rst_n = 1'b0;
   logic       btn_startstop = 1'b0, btn_inc = 1'b0, btn_clear = 1'b0;
   logic       sw_prog = 1'b0, sw_up = 1'b1, sw_min = 1'b0, zero = 1'b0;
   logic       run, dir_up, load, clear, capture, beep;
   logic [5:0] preset_min, preset_sec;
   logic [2:0] state_out;

   always #5 clock = ~clock;

   stopwatch_ctrl dut (
      .clock(clock), .rst_n(rst_n),
      .btn_startstop(btn_startstop), .btn_inc(btn_inc), .btn_clear(btn_clear),
      .sw_prog(sw_prog), .sw_up(sw_up), .sw_min(sw_min), .zero(zero),
      .run(run), .dir_up(dir_up), .load(load), .clear(clear),
      .preset_min(preset_min), .preset_sec(preset_sec),
      .capture(capture), .beep(beep), .state_out(state_out)
   );

   typedef struct packed {
      logic       run;
      logic       dir_up;
      logic       load;
      logic       clear;
      logic       capture;
      logic       beep;
      logic [2:0] st;
      logic [5:0] pmin;
      logic [5:0] psec;
   } obs_t;

   obs_t  exp_q[$];
   string name_q[$];
   int    n_cmp = 0;
   int    n_bad = 0;
   logic  chk = 1'b0;
   event  ev_async;

   function automatic obs_t mk(input logic r, input logic d, input logic ld, input logic cl,
                               input logic cp, input logic bp, input logic [2:0] st,
                               input logic [5:0] mn, input logic [5:0] sc);
      obs_t o;
      o = {r, d, ld, cl, cp, bp, st, mn, sc};
      return o;
   endfunction

   task automatic check_one();
      obs_t  a, e;
      string nm;
      a = {run, dir_up, load, clear, capture, beep, state_out, preset_min, preset_sec};
      n_cmp++;
      if (exp_q.size() == 0) begin
         n_bad++;
         $display("FAIL unexpected_output @%0t: got run=%b dir=%b ld=%b clr=%b cap=%b bp=%b st=%0d, expected no pulse",
                  $time, a.run, a.dir_up, a.load, a.clear, a.capture, a.beep, a.st);
      end else begin
         e  = exp_q.pop_front();
         nm = name_q.pop_front();
         if (a !== e) begin
            n_bad++;
            $display("FAIL %s @%0t: got run=%b dir=%b ld=%b clr=%b cap=%b bp=%b st=%0d pre=%0d:%0d, expected run=%b dir=%b ld=%b clr=%b cap=%b bp=%b st=%0d pre=%0d:%0d",
                     nm, $time, a.run, a.dir_up, a.load, a.clear, a.capture, a.beep, a.st, a.pmin, a.psec,
                     e.run, e.dir_up, e.load, e.clear, e.capture, e.beep, e.st, e.pmin, e.psec);
         end
      end
   endtask

   always @(negedge clock)
      if (rst_n === 1'b1 && (chk || load || clear || capture || beep)) check_one();

   always @(ev_async) check_one();

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic press(input logic ss, input logic inc, input logic clr, input logic z);
      tick();
      btn_startstop = ss; btn_inc = inc; btn_clear = clr; zero = z;
      tick();
      btn_startstop = 1'b0; btn_inc = 1'b0; btn_clear = 1'b0; zero = 1'b0;
   endtask

   task automatic expect_now(input obs_t e, input string nm);
      exp_q.push_back(e);
      name_q.push_back(nm);
      chk = 1'b1;
      @(negedge clock);
      #1 chk = 1'b0;
   endtask

   initial begin
      #200_000;
      $display("FAIL watchdog: got no finish, expected end of stimulus");
      $fatal(1, "timeout");
   end

   initial begin
      repeat (3) tick();
      rst_n = 1'b1;
      tick();
      expect_now(mk(0,1,0,0,0,0,0,0,0), "reset");
      repeat (5) tick();

      // up run, pause, resume, clear
      press(1,0,0,0); expect_now(mk(1,1,0,1,0,0,2,0,0), "up_start");
      tick();         expect_now(mk(1,1,0,0,0,0,2,0,0), "up_clear_1cyc");
      repeat (30) tick();
      press(1,0,0,0); expect_now(mk(0,1,0,0,1,0,3,0,0), "up_pause_capture");
      press(1,0,0,0); expect_now(mk(1,1,0,0,0,0,2,0,0), "resume");
      press(0,0,1,0); expect_now(mk(0,1,0,1,0,0,0,0,0), "run_clear");
      press(0,1,0,0); expect_now(mk(0,1,0,0,0,0,0,0,0), "inc_idle_ignored");

      // programming
      tick(); sw_prog = 1'b1; tick();
      expect_now(mk(0,1,0,0,0,0,1,0,0), "enter_prog");
      sw_min = 1'b1;
      repeat (3) press(0,1,0,0);
      expect_now(mk(0,1,0,0,0,0,1,3,0), "min_3");
      sw_min = 1'b0;
      repeat (59) press(0,1,0,0);
      expect_now(mk(0,1,0,0,0,0,1,3,59), "sec_59");
      press(0,1,0,0); expect_now(mk(0,1,0,0,0,0,1,3,0), "sec_wrap");
      press(0,1,0,0); expect_now(mk(0,1,0,0,0,0,1,3,1), "sec_wrap_plus1");
      press(1,0,0,0); expect_now(mk(0,1,0,0,0,0,1,3,1), "ss_in_prog_ignored");
      press(0,0,1,0); expect_now(mk(0,1,0,0,0,0,1,0,0), "prog_clear");
      repeat (5) press(0,1,0,0);
      sw_prog = 1'b0; tick();
      expect_now(mk(0,1,0,0,0,0,0,0,5), "exit_prog");

      // countdown to expiry
      sw_up = 1'b0;
      press(1,0,0,0); expect_now(mk(1,0,1,0,0,0,2,0,5), "down_start_load");
      tick();         expect_now(mk(1,0,0,0,0,0,2,0,5), "load_1cyc");
      press(0,0,0,1); expect_now(mk(0,0,0,0,0,1,4,0,5), "expire_beep");
      tick();         expect_now(mk(0,0,0,0,0,0,4,0,5), "beep_1cyc");
      press(1,0,0,0); expect_now(mk(0,0,0,1,0,0,0,0,5), "done_to_idle");

      // zero beats startstop
      press(1,0,0,0); expect_now(mk(1,0,1,0,0,0,2,0,5), "down_start2");
      press(1,0,0,1); expect_now(mk(0,0,0,0,0,1,4,0,5), "zero_beats_ss");
      press(0,0,1,0); expect_now(mk(0,0,0,1,0,0,0,0,5), "done_clear");

      // up run ignores zero, then async reset with startstop held
      sw_up = 1'b1;
      press(1,0,0,0); expect_now(mk(1,1,0,1,0,0,2,0,5), "up_start2");
      press(0,0,0,1); expect_now(mk(1,1,0,0,0,0,2,0,5), "zero_up_ignored");
      @(posedge clock);
      #3;
      btn_startstop = 1'b1;
      rst_n = 1'b0;
      #1;
      exp_q.push_back(mk(0,1,0,0,0,0,0,0,0));
      name_q.push_back("async_reset");
      -> ev_async;
      #1;
      repeat (2) tick();
      rst_n = 1'b1;
      repeat (3) tick();
      expect_now(mk(0,1,0,0,0,0,0,0,0), "held_through_reset");
      btn_startstop = 1'b0;
      tick();
      expect_now(mk(0,1,0,0,0,0,0,0,0), "release_no_start");

      // zero preset countdown start is ignored
      sw_up = 1'b0;
      press(1,0,0,0); expect_now(mk(0,1,0,0,0,0,0,0,0), "zero_preset_ignored");

      // clear beats startstop in RUN; clear from PAUSE
      sw_up = 1'b1;
      press(1,0,0,0); expect_now(mk(1,1,0,1,0,0,2,0,0), "up_start3");
      press(1,0,1,0); expect_now(mk(0,1,0,1,0,0,0,0,0), "clear_beats_ss");
      press(1,0,0,0); expect_now(mk(1,1,0,1,0,0,2,0,0), "up_start4");
      press(1,0,0,0); expect_now(mk(0,1,0,0,1,0,3,0,0), "pause2_capture");
      press(0,0,1,0); expect_now(mk(0,1,0,1,0,0,0,0,0), "pause_clear");

      repeat (5) tick();
      if (exp_q.size() != 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL queue_drain: got %0d pending, expected 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
Sequencing controller for the stopwatch datapath. Converts debounced button levels and mode switches into run/load/clear commands, and holds the programmable countdown preset (minutes:seconds). Emits single-cycle capture and beep pulses for the leaderboard and sound blocks. Sits between the debouncers and the stopwatch/leaderboard/music instances in top.

Parameters:
MIN_MAX, 59, highest preset minute value before wrap to 0
SEC_MAX, 59, highest preset second value before wrap to 0
REPEAT_DELAY, 50_000_000, cycles inc must be held before auto-repeat starts (optional feature only)
REPEAT_PERIOD, 10_000_000, cycles between auto-repeat increments (optional feature only)

Ports:
clock  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous, active-low reset
btn_startstop  in  1  debounced start/stop button level
btn_inc  in  1  debounced increment button level
btn_clear  in  1  debounced clear button level
sw_prog  in  1  1 = enter preset programming (honoured in IDLE only)
sw_up  in  1  1 = count up, 0 = count down; sampled at start
sw_min  in  1  1 = inc targets minutes, 0 = seconds
zero  in  1  datapath reports time == 0
run  out  1  level: datapath counts while high
dir_up  out  1  direction latched at start
load  out  1  1-cycle pulse: datapath loads preset
clear  out  1  1-cycle pulse: datapath clears to 0
preset_min  out  6  programmed minutes
preset_sec  out  6  programmed seconds
capture  out  1  1-cycle pulse: leaderboard latches current time
beep  out  1  1-cycle pulse: countdown expired
state_out  out  3  current state encoding, drives LEDs

Behaviour:
- Reset (async, rst_n=0): state IDLE; run, load, clear, capture, beep = 0; dir_up = 1; preset_min = preset_sec = 0; edge-detect history regs = 1 (a button held through reset release does not fire).
- Button events: rising edge = level & ~prev. An edge present before clock edge k takes effect at edge k. State, run, and pulses are registered and visible after edge k. Pulses last exactly one cycle.
- Encoding: IDLE=0, PROG=1, RUN=2, PAUSE=3, DONE=4.
- IDLE:
  - sw_prog=1 -> PROG.
  - startstop with sw_up=1 -> dir_up=1, clear pulse, RUN.
  - startstop with sw_up=0 and preset nonzero -> dir_up=0, load pulse, RUN.
  - startstop with sw_up=0 and preset 0 -> ignored.
  - sw_prog has priority over startstop.
- PROG:
  - inc adds 1 to minutes (sw_min=1) or seconds (sw_min=0); MIN_MAX/SEC_MAX wrap to 0, no carry between fields.
  - clear zeroes both preset fields.
  - sw_prog=0 -> IDLE.
  - startstop ignored.
- RUN: run=1.
  - clear -> IDLE, clear pulse.
  - else zero with dir_up=0 -> DONE, beep pulse, run drops the same edge.
  - else startstop -> PAUSE, with capture pulse if dir_up=1.
  - Priority: clear > zero > startstop.
- PAUSE: run=0.
  - clear -> IDLE, clear pulse.
  - else startstop -> RUN (no load or clear).
- DONE: run=0.
  - startstop or clear -> IDLE, clear pulse.
- sw_up/sw_prog changes outside IDLE are ignored. inc is ignored outside PROG.
- Reset mid-RUN: immediate IDLE, all outputs to reset values, preset lost.

Optional Feature:
STOPWATCH_CTRL_AUTOREPEAT_EN.
- Defined: in PROG, btn_inc held continuously for REPEAT_DELAY cycles after its edge produces one increment, then one per REPEAT_PERIOD cycles while held. The counter resets on release or on leaving PROG.
- Undefined: one increment per rising edge only; REPEAT_* unused, no counter logic.

Decomposition:
- Package stopwatch_pkg:
  - state encoding constants (3-bit), state_out width
  - preset field width (6)
  - default MIN_MAX/SEC_MAX
- Sub-module btn_edge: rising-edge detector with prev reg resetting to 1, instantiated three times.
- Auto-repeat counter stays inline, under the macro.

Test Plan:
- Up run: reset, sw_up=1, startstop edge at cycle 10 -> cycle 11 clear=1 for one cycle, run=1, state_out=2. Startstop at 50 -> capture=1 at 51, run=0, state_out=3.
- Program: sw_prog=1 -> state 1. sw_min=1, 3 inc edges; sw_min=0, 61 inc edges -> preset_min=3, preset_sec=1 (59->0 wrap, minutes unchanged).
- Countdown: preset 0:05, sw_up=0, startstop -> load pulse, run=1. Drive zero=1 -> next cycle beep=1 for one cycle, run=0, state_out=4. Startstop -> clear pulse, IDLE.
- Zero-preset start: preset 0:00, sw_up=0, startstop -> no load, run stays 0, state_out=0.
- Simultaneous: in RUN, clear and startstop edges same cycle -> IDLE with clear pulse, no capture. Zero and startstop same cycle (down) -> DONE with beep, no PAUSE.
- Reset mid-run: rst_n low asynchronously during RUN -> run=0, state_out=0, preset=0 without a clock edge. btn_startstop held across release -> no RUN.
